// File: rtl/signext_arb_if.sv
// rtl/signext_arb_if.sv - requester and result handshake bundle for signext_arb
interface signext_arb_if #(
   parameter int K = 4,
   parameter int N = 20,
   parameter int M = 32
);
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   logic [K-1:0]   i_req_valid;
   logic [K-1:0]   o_req_ready;
   logic [K*N-1:0] i_req_data;
   logic           o_out_valid;
   logic           i_out_ready;
   logic [M-1:0]   o_out_data;
   logic [IW-1:0]  o_out_id;

   modport slave (
      input  i_req_valid, i_req_data, i_out_ready,
      output o_req_ready, o_out_valid, o_out_data, o_out_id
   );

   modport master (
      output i_req_valid, i_req_data, i_out_ready,
      input  o_req_ready, o_out_valid, o_out_data, o_out_id
   );
endinterface

// File: rtl/signext_arb.sv
// rtl/signext_arb.sv - round-robin arbiter feeding one registered N-to-M sign-extension stage
module signext_arb #(
   parameter int K = 4,
   parameter int N = 20,
   parameter int M = 32
) (
   input logic          i_clk,
   input logic          i_rst_n,
   signext_arb_if.slave bus
);
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   logic [IW-1:0] ptr;
   logic          out_valid;
   logic [M-1:0]  out_data;
   logic [IW-1:0] out_id;

   logic          acc;
   logic          found;
   logic [IW-1:0] gnt;
   logic [IW-1:0] ptr_next;
   logic [N-1:0]  sel;
   logic [M-1:0]  ext;
   int            idx;

   assign acc = !out_valid || bus.i_out_ready;

   // Scan from ptr upward, wrapping at K; the first valid requester wins.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = 0;
      for (int i = 0; i < K; i++) begin
         idx = int'(ptr) + i;
         if (idx >= K) idx = idx - K;
         for (int k = 0; k < K; k++) begin
            if (!found && (k == idx) && bus.i_req_valid[k]) begin
               found = 1'b1;
               gnt   = IW'(k);
            end
         end
      end
   end

   always_comb begin
      sel = '0;
      for (int k = 0; k < K; k++) begin
         if (gnt == IW'(k)) sel = bus.i_req_data[k*N +: N];
      end
   end

   generate
      if (M > N) begin : g_ext
         assign ext = {{(M-N){sel[N-1]}}, sel};
      end else begin : g_pass
         assign ext = sel;
      end
   endgenerate

   assign ptr_next = (gnt == IW'(K-1)) ? '0 : gnt + IW'(1);

   assign bus.o_req_ready = (i_rst_n && acc && found) ? (K'(1) << gnt) : '0;
   assign bus.o_out_valid = out_valid;
   assign bus.o_out_data  = out_data;
   assign bus.o_out_id    = out_id;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         ptr       <= '0;
      end else if (acc && found) begin
         out_valid <= 1'b1;
         out_data  <= ext;
         out_id    <= gnt;
         ptr       <= ptr_next;
      end else if (out_valid && bus.i_out_ready) begin
         // Drain only; data and id keep their last values.
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_signext_arb.sv
// tb/tb_signext_arb.sv - directed self-checking bench for signext_arb (K=4, N=20, M=32)
module tb_signext_arb;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   signext_arb_if #(.K(4), .N(20), .M(32)) bus ();

   signext_arb #(.K(4), .N(20), .M(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_data(input int k, input logic [19:0] v);
      bus.i_req_data[k*20 +: 20] = v;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_req_valid = 4'b0000;
      bus.i_out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_req_valid = 4'b1111;
      bus.i_out_ready = 1'b1;
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0000) begin
         fails++; $display("FAIL reset_ready_gated: got %b exp %b", bus.o_req_ready, 4'b0000);
      end
      tick();
      tick();
      tests++;
      if (bus.o_out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_valid: got %b exp 0", bus.o_out_valid);
      end
      tests++;
      if (bus.o_out_data !== 32'h0) begin
         fails++; $display("FAIL reset_data: got %h exp 00000000", bus.o_out_data);
      end
      tests++;
      if (bus.o_out_id !== 2'd0) begin
         fails++; $display("FAIL reset_id: got %0d exp 0", bus.o_out_id);
      end
      bus.i_req_valid = 4'b0000;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_data(2, 20'h80000);
      bus.i_req_valid = 4'b0100;
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0100) begin
         fails++; $display("FAIL single_ready: got %b exp %b", bus.o_req_ready, 4'b0100);
      end
      tick();
      tests++;
      if (bus.o_out_valid !== 1'b1) begin
         fails++; $display("FAIL single_valid: got %b exp 1", bus.o_out_valid);
      end
      tests++;
      if (bus.o_out_data !== 32'hFFF80000) begin
         fails++; $display("FAIL single_neg_data: got %h exp fff80000", bus.o_out_data);
      end
      tests++;
      if (bus.o_out_id !== 2'd2) begin
         fails++; $display("FAIL single_id: got %0d exp 2", bus.o_out_id);
      end
      set_data(2, 20'h7FFFF);
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0100) begin
         fails++; $display("FAIL single_ready2: got %b exp %b", bus.o_req_ready, 4'b0100);
      end
      tick();
      tests++;
      if (bus.o_out_data !== 32'h0007FFFF) begin
         fails++; $display("FAIL single_pos_data: got %h exp 0007ffff", bus.o_out_data);
      end
      bus.i_req_valid = 4'b0000;
   endtask

   task automatic test_round_robin();
      logic [31:0] ext_tab [4];
      logic [3:0]  exp_rdy;
      ext_tab[0] = 32'h00000001;
      ext_tab[1] = 32'hFFFFFFFE;
      ext_tab[2] = 32'h00012345;
      ext_tab[3] = 32'hFFF80001;
      do_reset();
      set_data(0, 20'h00001);
      set_data(1, 20'hFFFFE);
      set_data(2, 20'h12345);
      set_data(3, 20'h80001);
      bus.i_req_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         exp_rdy = 4'b0001 << (c % 4);
         #1;
         tests++;
         if (bus.o_req_ready !== exp_rdy) begin
            fails++; $display("FAIL rr_ready[%0d]: got %b exp %b", c, bus.o_req_ready, exp_rdy);
         end
         tick();
         tests++;
         if (bus.o_out_valid !== 1'b1 || bus.o_out_id !== 2'(c % 4)) begin
            fails++; $display("FAIL rr_id[%0d]: got v=%b id=%0d exp v=1 id=%0d", c, bus.o_out_valid, bus.o_out_id, c % 4);
         end
         tests++;
         if (bus.o_out_data !== ext_tab[c % 4]) begin
            fails++; $display("FAIL rr_data[%0d]: got %h exp %h", c, bus.o_out_data, ext_tab[c % 4]);
         end
      end
      bus.i_req_valid = 4'b0000;
   endtask

   task automatic test_backpressure();
      do_reset();
      set_data(0, 20'hFFFFF);
      set_data(1, 20'h00042);
      set_data(2, 20'h00000);
      set_data(3, 20'h00000);
      bus.i_req_valid = 4'b0001;
      tick();
      bus.i_out_ready = 1'b0;
      bus.i_req_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (bus.o_req_ready !== 4'b0000) begin
            fails++; $display("FAIL bp_ready[%0d]: got %b exp 0000", c, bus.o_req_ready);
         end
         tick();
         tests++;
         if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== 32'hFFFFFFFF || bus.o_out_id !== 2'd0) begin
            fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d exp v=1 d=ffffffff id=0", c, bus.o_out_valid, bus.o_out_data, bus.o_out_id);
         end
      end
      bus.i_out_ready = 1'b1;
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0010) begin
         fails++; $display("FAIL bp_release_ready: got %b exp 0010", bus.o_req_ready);
      end
      tick();
      tests++;
      if (bus.o_out_id !== 2'd1 || bus.o_out_data !== 32'h00000042) begin
         fails++; $display("FAIL bp_release_out: got id=%0d d=%h exp id=1 d=00000042", bus.o_out_id, bus.o_out_data);
      end
      bus.i_req_valid = 4'b0000;
   endtask

   task automatic test_pointer_skip();
      do_reset();
      set_data(2, 20'h00001);
      bus.i_req_valid = 4'b0100;
      tick();
      set_data(1, 20'h00010);
      set_data(3, 20'h80000);
      bus.i_req_valid = 4'b1010;
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b1000) begin
         fails++; $display("FAIL skip_grant3: got %b exp 1000", bus.o_req_ready);
      end
      tick();
      tests++;
      if (bus.o_out_id !== 2'd3 || bus.o_out_data !== 32'hFFF80000) begin
         fails++; $display("FAIL skip_out3: got id=%0d d=%h exp id=3 d=fff80000", bus.o_out_id, bus.o_out_data);
      end
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0010) begin
         fails++; $display("FAIL wrap_grant1: got %b exp 0010", bus.o_req_ready);
      end
      tick();
      tests++;
      if (bus.o_out_id !== 2'd1 || bus.o_out_data !== 32'h00000010) begin
         fails++; $display("FAIL wrap_out1: got id=%0d d=%h exp id=1 d=00000010", bus.o_out_id, bus.o_out_data);
      end
      bus.i_req_valid = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (bus.o_req_ready !== 4'b0000) begin
            fails++; $display("FAIL idle_ready[%0d]: got %b exp 0000", c, bus.o_req_ready);
         end
         tick();
      end
      tests++;
      if (bus.o_out_valid !== 1'b0) begin
         fails++; $display("FAIL idle_valid: got %b exp 0", bus.o_out_valid);
      end
      bus.i_req_valid = 4'b1111;
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0100) begin
         fails++; $display("FAIL idle_ptr_held: got %b exp 0100", bus.o_req_ready);
      end
      tick();
      tests++;
      if (bus.o_out_id !== 2'd2) begin
         fails++; $display("FAIL idle_out_id: got %0d exp 2", bus.o_out_id);
      end
      bus.i_req_valid = 4'b0000;
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_data(0, 20'h00005);
      set_data(1, 20'h00006);
      bus.i_req_valid = 4'b0011;
      tick();
      tick();
      tests++;
      if (bus.o_out_valid !== 1'b1 || bus.o_out_id !== 2'd1) begin
         fails++; $display("FAIL mid_pre: got v=%b id=%0d exp v=1 id=1", bus.o_out_valid, bus.o_out_id);
      end
      rst_n = 1'b0;
      bus.i_req_valid = 4'b1111;
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0000) begin
         fails++; $display("FAIL mid_ready_gated: got %b exp 0000", bus.o_req_ready);
      end
      tick();
      tests++;
      if (bus.o_out_valid !== 1'b0 || bus.o_out_data !== 32'h0 || bus.o_out_id !== 2'd0) begin
         fails++; $display("FAIL mid_cleared: got v=%b d=%h id=%0d exp v=0 d=00000000 id=0", bus.o_out_valid, bus.o_out_data, bus.o_out_id);
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (bus.o_req_ready !== 4'b0001) begin
         fails++; $display("FAIL mid_first_grant: got %b exp 0001", bus.o_req_ready);
      end
      tick();
      tests++;
      if (bus.o_out_id !== 2'd0 || bus.o_out_data !== 32'h00000005) begin
         fails++; $display("FAIL mid_first_out: got id=%0d d=%h exp id=0 d=00000005", bus.o_out_id, bus.o_out_data);
      end
      bus.i_req_valid = 4'b0000;
   endtask

   task automatic test_drain();
      do_reset();
      set_data(3, 20'h80001);
      bus.i_req_valid = 4'b1000;
      tick();
      tests++;
      if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== 32'hFFF80001 || bus.o_out_id !== 2'd3) begin
         fails++; $display("FAIL drain_pre: got v=%b d=%h id=%0d exp v=1 d=fff80001 id=3", bus.o_out_valid, bus.o_out_data, bus.o_out_id);
      end
      bus.i_req_valid = 4'b0000;
      tick();
      tests++;
      if (bus.o_out_valid !== 1'b0) begin
         fails++; $display("FAIL drain_valid: got %b exp 0", bus.o_out_valid);
      end
      tests++;
      if (bus.o_out_data !== 32'hFFF80001 || bus.o_out_id !== 2'd3) begin
         fails++; $display("FAIL drain_retain: got d=%h id=%0d exp d=fff80001 id=3", bus.o_out_data, bus.o_out_id);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.i_req_valid = 4'b0000;
      bus.i_req_data  = '0;
      bus.i_out_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_pointer_skip();
      test_reset_mid();
      test_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
